// File: rtl/uart_send.sv
// uart_send: FIFO-buffered 8N1 UART transmitter with back-to-back frames.
// txd and tfin are registered, so they trail the FSM state by one cycle.
module uart_send #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_ce,
    input  logic [7:0] din,
    output logic       full,
    output logic       txd,
    output logic       busy,
    output logic       tfin
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          txd_q, txd_d, tfin_q, tfin_d;
    logic [7:0]    mem [FIFO_DEPTH];
    logic          push, pop, bit_end;

    assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign busy = (state_q != IDLE) || (cnt_q != '0);
    assign txd  = txd_q;
    assign tfin = tfin_q;

    always_comb begin
        push    = send_ce && !full;
        bit_end = baud_q == LAST;
        // A pop happens from IDLE or at the final edge of a stop bit, so frames chain with no gap.
        pop     = (state_q == IDLE || (state_q == STOP && bit_end)) && cnt_q != '0;
        state_d = state_q;
        baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                    sh_d    = mem[rp_q];
                    idx_d   = '0;
                end
            end
            START: state_d = bit_end ? DATA : START;
            DATA: begin
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = pop ? START : IDLE;
                    if (pop) begin
                        sh_d  = mem[rp_q];
                        idx_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        txd_d  = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
        tfin_d = state_q == STOP && bit_end;
        wp_d   = push ? wp_q + 1'b1 : wp_q;
        rp_d   = pop ? rp_q + 1'b1 : rp_q;
        cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            tfin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            tfin_q  <= tfin_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= din;
    end
endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: directed checks of uart_send with 4 clocks per bit and a 4-deep FIFO.
module tb_uart_send;
    logic       clk, rst, send_ce, full, txd, busy, tfin;
    logic [7:0] din;
    int         checks = 0, passes = 0;

    uart_send #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .send_ce(send_ce), .din(din),
        .full(full), .txd(txd), .busy(busy), .tfin(tfin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    // Expects the next falling edge to sample the first cycle of the start bit.
    task automatic check_frame(input logic [7:0] b);
        for (int k = 0; k < 40; k++) begin
            int   pos;
            logic e;
            @(negedge clk);
            pos = k / 4;
            e = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos-1];
            chk($sformatf("txd byte %h cycle %0d", b, k + 1), {7'd0, txd}, {7'd0, e});
            chk($sformatf("tfin byte %h cycle %0d", b, k + 1), {7'd0, tfin}, {7'd0, k == 39});
        end
    endtask

    initial begin
        logic [7:0] v6 [6];
        logic [7:0] v5 [5];
        v6 = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h33, 8'h81};
        v5 = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hC3};
        rst = 1'b1; send_ce = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst txd", {7'd0, txd}, 8'd1);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst full", {7'd0, full}, 8'd0);
        chk("rst tfin", {7'd0, tfin}, 8'd0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle txd", {7'd0, txd}, 8'd1);
        end
        // single byte, latency and end of frame
        send_ce = 1'b1; din = 8'hA5;
        @(negedge clk);
        send_ce = 1'b0;
        chk("a5 busy after write", {7'd0, busy}, 8'd1);
        chk("a5 txd t0", {7'd0, txd}, 8'd1);
        @(negedge clk);
        chk("a5 txd t1", {7'd0, txd}, 8'd1);
        check_frame(8'hA5);
        @(negedge clk);
        chk("a5 busy after", {7'd0, busy}, 8'd0);
        chk("a5 txd after", {7'd0, txd}, 8'd1);
        // six consecutive writes, the sixth hits a full FIFO
        send_ce = 1'b1; din = v6[0];
        fork
            begin
                for (int i = 1; i < 6; i++) begin
                    @(negedge clk);
                    din = v6[i];
                    chk($sformatf("burst full %0d", i), {7'd0, full}, {7'd0, i == 5});
                end
                @(negedge clk);
                send_ce = 1'b0;
                chk("burst full after drop", {7'd0, full}, 8'd1);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) check_frame(v6[i]);
            end
        join
        @(negedge clk);
        chk("burst busy after", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("burst no sixth frame", {7'd0, txd}, 8'd1);
        end
        // write during the stop bit chains the next frame without a gap
        send_ce = 1'b1; din = 8'h12;
        fork
            begin
                @(negedge clk);
                send_ce = 1'b0;
                repeat (37) @(negedge clk);
                send_ce = 1'b1; din = 8'h34;
                @(negedge clk);
                send_ce = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                check_frame(8'h12);
                check_frame(8'h34);
            end
        join
        @(negedge clk);
        chk("stop write busy after", {7'd0, busy}, 8'd0);
        // reset in data bit 3 of 0x3C with two bytes queued
        send_ce = 1'b1; din = 8'h3C;
        @(negedge clk);
        din = 8'hAA;
        @(negedge clk);
        din = 8'hBB;
        @(negedge clk);
        send_ce = 1'b0;
        chk("3c start bit", {7'd0, txd}, 8'd0);
        repeat (17) @(negedge clk);
        chk("3c data bit 3", {7'd0, txd}, 8'd1);
        chk("3c busy before rst", {7'd0, busy}, 8'd1);
        #1 rst = 1'b1;
        #1;
        chk("async rst txd", {7'd0, txd}, 8'd1);
        chk("async rst busy", {7'd0, busy}, 8'd0);
        chk("async rst full", {7'd0, full}, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("post rst txd", {7'd0, txd}, 8'd1);
            chk("post rst busy", {7'd0, busy}, 8'd0);
        end
        // write while full with a simultaneous pop is dropped
        send_ce = 1'b1; din = v5[0];
        fork
            begin
                for (int i = 1; i < 5; i++) begin
                    @(negedge clk);
                    din = v5[i];
                end
                @(negedge clk);
                send_ce = 1'b0;
                chk("pop full a", {7'd0, full}, 8'd1);
                repeat (36) @(negedge clk);
                chk("pop full b", {7'd0, full}, 8'd1);
                send_ce = 1'b1; din = 8'hEE;
                @(negedge clk);
                send_ce = 1'b0;
                chk("pop full after", {7'd0, full}, 8'd0);
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 5; i++) check_frame(v5[i]);
            end
        join
        @(negedge clk);
        chk("pop busy after", {7'd0, busy}, 8'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pop no extra frame", {7'd0, txd}, 8'd1);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
